// File: rtl/gouram_timing_pkg.sv
// Shared types and constants for the trace timing resolver: FSM states,
// the default-width timing record and the "no time available" marker.
package gouram_timing_pkg;

  localparam int REC_DATA_WIDTH = 32;
  localparam int NO_TIME        = -1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_PUSH
  } resolver_state_e;

  typedef struct packed {
    logic [REC_DATA_WIDTH-1:0]        addr;
    logic signed [REC_DATA_WIDTH-1:0] start_time;
    logic signed [REC_DATA_WIDTH-1:0] end_time;
    logic                             found;
  } timing_rec_t;

endpackage

// File: rtl/signal_tracker_if.sv
// Connection to the downstream signal_tracker; time_test is the view of the
// block that asks for timing answers, tracker is the view of the tracker itself.
interface signal_tracker_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0]        counter;
  logic                         recalculate_time;
  logic [7:0]                   value_in;
  logic                         data_valid;
  logic signed [DATA_WIDTH-1:0] time_out [2];

  modport time_test (
    output counter, recalculate_time, value_in,
    input  data_valid, time_out
  );

  modport tracker (
    input  counter, recalculate_time, value_in,
    output data_valid, time_out
  );

endinterface

// File: rtl/trace_record_fifo.sv
// Small synchronous FIFO of resolved timing records; accepts a push while full
// only when a pop happens in the same cycle, so nothing is ever overwritten.
module trace_record_fifo #(
  parameter int  DEPTH = 4,
  parameter type rec_t = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  rec_t wdata,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/trace_timing_resolver.sv
// Turns timing queries into tracker requests and queues one record per query
// holding the tracker's start/end answer, or NO_TIME on timeout or empty window.
module trace_timing_resolver
  import gouram_timing_pkg::*;
#(
  parameter int BUFFER_WIDTH   = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         event_valid,
  output logic                         event_ready,
  input  logic [DATA_WIDTH-1:0]        event_addr,
  input  logic [7:0]                   event_cycles_back,
  output logic [DATA_WIDTH-1:0]        counter,
  output logic                         recalculate_time,
  output logic [7:0]                   value_in,
  input  logic                         trk_data_valid,
  input  logic signed [DATA_WIDTH-1:0] trk_time_start,
  input  logic signed [DATA_WIDTH-1:0] trk_time_end,
  output logic                         rec_valid,
  input  logic                         rec_ready,
  output logic [DATA_WIDTH-1:0]        rec_addr,
  output logic signed [DATA_WIDTH-1:0] rec_start,
  output logic signed [DATA_WIDTH-1:0] rec_end,
  output logic                         rec_found
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] NO_TIME_W = DATA_WIDTH'(NO_TIME);

  // Same field layout as timing_rec_t, sized by DATA_WIDTH.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]        addr;
    logic signed [DATA_WIDTH-1:0] start_time;
    logic signed [DATA_WIDTH-1:0] end_time;
    logic                         found;
  } rec_t;

  resolver_state_e       state_q, state_d;
  logic [DATA_WIDTH-1:0] counter_q, counter_d;
  logic [7:0]            value_in_q, value_in_d;
  logic [TW-1:0]         timer_q, timer_d;
  rec_t                  rec_q, rec_d;
  logic                  recalc_q, recalc_d;
  logic                  ready_q, ready_d;
  logic [7:0]            window_clamped;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  rec_t                  head_rec;

  signal_tracker_if #(.DATA_WIDTH(DATA_WIDTH)) trk_if ();

  assign trk_if.counter          = counter_q;
  assign trk_if.recalculate_time = recalc_q;
  assign trk_if.value_in         = value_in_q;
  assign trk_if.data_valid       = trk_data_valid;
  assign trk_if.time_out[0]      = trk_time_start;
  assign trk_if.time_out[1]      = trk_time_end;

  assign counter          = trk_if.counter;
  assign recalculate_time = trk_if.recalculate_time;
  assign value_in         = trk_if.value_in;
  assign event_ready      = ready_q;

  always_comb begin
    if (32'(event_cycles_back) > 32'(BUFFER_WIDTH)) begin
      window_clamped = 8'(BUFFER_WIDTH);
    end else begin
      window_clamped = event_cycles_back;
    end
  end

  // ARM lets the tracker drop its stale data_valid, so only WAIT listens to it.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q + DATA_WIDTH'(1);
    value_in_d = value_in_q;
    timer_d    = timer_q;
    rec_d      = rec_q;
    fifo_push  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (event_valid && ready_q) begin
          rec_d.addr = event_addr;
          value_in_d = window_clamped;
          timer_d    = '0;
          if (event_cycles_back == 8'd0) begin
            rec_d.start_time = NO_TIME_W;
            rec_d.end_time   = NO_TIME_W;
            rec_d.found      = 1'b0;
            state_d          = ST_PUSH;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (trk_if.data_valid) begin
          rec_d.start_time = trk_if.time_out[0];
          rec_d.end_time   = trk_if.time_out[1];
          rec_d.found      = 1'b1;
          state_d          = ST_PUSH;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rec_d.start_time = NO_TIME_W;
          rec_d.end_time   = NO_TIME_W;
          rec_d.found      = 1'b0;
          state_d          = ST_PUSH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_PUSH: begin
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    recalc_d = (state_d == ST_ARM) || (state_d == ST_WAIT);
    ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      value_in_q <= '0;
      timer_q    <= '0;
      rec_q      <= '0;
      recalc_q   <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      value_in_q <= value_in_d;
      timer_q    <= timer_d;
      rec_q      <= rec_d;
      recalc_q   <= recalc_d;
      ready_q    <= ready_d;
    end
  end

  assign fifo_pop = !fifo_empty && rec_ready;

  trace_record_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rec_q),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rec_valid = !fifo_empty;
  assign rec_addr  = head_rec.addr;
  assign rec_start = head_rec.start_time;
  assign rec_end   = head_rec.end_time;
  assign rec_found = head_rec.found;

endmodule

// File: tb/tb_trace_timing_resolver.sv
// Scoreboard bench for trace_timing_resolver: expected records are queued as
// queries are issued and compared when the DUT pops them.
`timescale 1ns/1ps
module tb_trace_timing_resolver;
  import gouram_timing_pkg::*;

  localparam int DW = 32;
  localparam logic signed [DW-1:0] NT = -1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 event_valid = 1'b0;
  logic                 event_ready;
  logic [DW-1:0]        event_addr = '0;
  logic [7:0]           event_cycles_back = '0;
  logic [DW-1:0]        counter;
  logic                 recalculate_time;
  logic [7:0]           value_in;
  logic                 trk_data_valid = 1'b0;
  logic signed [DW-1:0] trk_time_start = '0;
  logic signed [DW-1:0] trk_time_end = '0;
  logic                 rec_valid;
  logic                 rec_ready = 1'b1;
  logic [DW-1:0]        rec_addr;
  logic signed [DW-1:0] rec_start;
  logic signed [DW-1:0] rec_end;
  logic                 rec_found;

  int          checks = 0;
  int          passes = 0;
  logic [DW-1:0] exp_counter;
  timing_rec_t exp_q [$];
  timing_rec_t want;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_counter <= '0;
    else        exp_counter <= exp_counter + 1;
  end

  trace_timing_resolver #(
    .BUFFER_WIDTH   (8),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .event_valid       (event_valid),
    .event_ready       (event_ready),
    .event_addr        (event_addr),
    .event_cycles_back (event_cycles_back),
    .counter           (counter),
    .recalculate_time  (recalculate_time),
    .value_in          (value_in),
    .trk_data_valid    (trk_data_valid),
    .trk_time_start    (trk_time_start),
    .trk_time_end      (trk_time_end),
    .rec_valid         (rec_valid),
    .rec_ready         (rec_ready),
    .rec_addr          (rec_addr),
    .rec_start         (rec_start),
    .rec_end           (rec_end),
    .rec_found         (rec_found)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic timing_rec_t head();
    timing_rec_t r;
    r.addr       = rec_addr;
    r.start_time = rec_start;
    r.end_time   = rec_end;
    r.found      = rec_found;
    return r;
  endfunction

  function automatic timing_rec_t mk_rec(logic [DW-1:0] a, logic signed [DW-1:0] s,
                                         logic signed [DW-1:0] e, logic f);
    timing_rec_t r;
    r.addr       = a;
    r.start_time = s;
    r.end_time   = e;
    r.found      = f;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    rec_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (counter !== '0) $display("[TB] FAIL reset_counter got %0d want 0", counter);
    else passes++;
    checks++;
    if (rec_valid !== 1'b0) $display("[TB] FAIL reset_rec_valid got %b want 0", rec_valid);
    else passes++;
    checks++;
    if (recalculate_time !== 1'b0) $display("[TB] FAIL reset_recalc got %b want 0", recalculate_time);
    else passes++;
    checks++;
    if (value_in !== 8'd0) $display("[TB] FAIL reset_value_in got %0d want 0", value_in);
    else passes++;
    // Release reset and offer a zero-window query in the same cycle.
    rst_n = 1'b1;
    event_valid = 1'b1;
    event_addr = 32'h55;
    event_cycles_back = 8'd0;
    exp_q.push_back(mk_rec(32'h55, NT, NT, 1'b0));
    tick();
    event_valid = 1'b0;
    checks++;
    if (counter !== 32'd1) $display("[TB] FAIL counter_after_release got %0d want 1", counter);
    else passes++;
    checks++;
    if (rec_valid !== 1'b0 || recalculate_time !== 1'b0)
      $display("[TB] FAIL zero_window_lat1 got valid=%b recalc=%b want 0 0", rec_valid, recalculate_time);
    else passes++;
    tick();
    checks++;
    if (exp_q.size() == 0) $display("[TB] FAIL zero_window_rec got record want none queued");
    else begin
      want = exp_q.pop_front();
      if (rec_valid !== 1'b1 || head() !== want || recalculate_time !== 1'b0)
        $display("[TB] FAIL zero_window_rec got v=%b %p want %p", rec_valid, head(), want);
      else passes++;
    end
    tick();
    checks++;
    if (rec_valid !== 1'b0 || counter !== 32'd3)
      $display("[TB] FAIL pop_and_count got valid=%b counter=%0d want 0 3", rec_valid, counter);
    else passes++;
  endtask

  task automatic test_basic();
    checks++;
    if (event_ready !== 1'b1) $display("[TB] FAIL basic_ready got %b want 1", event_ready);
    else passes++;
    event_valid = 1'b1;
    event_addr = 32'h100;
    event_cycles_back = 8'd3;
    exp_q.push_back(mk_rec(32'h100, 10, 12, 1'b1));
    tick();
    event_valid = 1'b0;
    checks++;
    if (recalculate_time !== 1'b1 || value_in !== 8'd3)
      $display("[TB] FAIL basic_arm got recalc=%b value_in=%0d want 1 3", recalculate_time, value_in);
    else passes++;
    repeat (2) tick();
    trk_data_valid = 1'b1;
    trk_time_start = 10;
    trk_time_end = 12;
    tick();
    trk_data_valid = 1'b0;
    checks++;
    if (rec_valid !== 1'b0 || recalculate_time !== 1'b0)
      $display("[TB] FAIL basic_push_cycle got valid=%b recalc=%b want 0 0", rec_valid, recalculate_time);
    else passes++;
    tick();
    checks++;
    if (exp_q.size() == 0) $display("[TB] FAIL basic_rec got record want none queued");
    else begin
      want = exp_q.pop_front();
      if (rec_valid !== 1'b1 || head() !== want)
        $display("[TB] FAIL basic_rec got v=%b %p want %p", rec_valid, head(), want);
      else passes++;
    end
    checks++;
    if (counter !== exp_counter) $display("[TB] FAIL basic_counter got %0d want %0d", counter, exp_counter);
    else passes++;
    tick();
  endtask

  task automatic test_clamp();
    logic [7:0] cbs  [4] = '{8'd1, 8'd7, 8'd8, 8'd20};
    logic [7:0] wins [4] = '{8'd1, 8'd7, 8'd8, 8'd8};
    for (int i = 0; i < 4; i++) begin
      event_valid = 1'b1;
      event_addr = 32'h300 + DW'(i);
      event_cycles_back = cbs[i];
      exp_q.push_back(mk_rec(32'h300 + DW'(i), 100 + i, -200 - i, 1'b1));
      tick();
      event_valid = 1'b0;
      checks++;
      if (value_in !== wins[i]) $display("[TB] FAIL clamp_value_in got %0d want %0d", value_in, wins[i]);
      else passes++;
      tick();
      trk_data_valid = 1'b1;
      trk_time_start = 100 + i;
      trk_time_end = -200 - i;
      tick();
      trk_data_valid = 1'b0;
      tick();
      checks++;
      if (exp_q.size() == 0) $display("[TB] FAIL clamp_rec got record want none queued");
      else begin
        want = exp_q.pop_front();
        if (rec_valid !== 1'b1 || head() !== want)
          $display("[TB] FAIL clamp_rec got v=%b %p want %p", rec_valid, head(), want);
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int high = 0;
    int seen_at = -1;
    event_valid = 1'b1;
    event_addr = 32'h400;
    event_cycles_back = 8'd5;
    exp_q.push_back(mk_rec(32'h400, NT, NT, 1'b0));
    tick();
    event_valid = 1'b0;
    // A stale answer during ARM must not be taken.
    for (int k = 1; k <= 40; k++) begin
      trk_data_valid = (k == 1);
      trk_time_start = 77;
      trk_time_end = 78;
      if (recalculate_time === 1'b1) high++;
      if (rec_valid === 1'b1) begin
        seen_at = k;
        break;
      end
      tick();
    end
    trk_data_valid = 1'b0;
    checks++;
    if (high != 17) $display("[TB] FAIL timeout_recalc_len got %0d want 17", high);
    else passes++;
    checks++;
    if (seen_at != 19) $display("[TB] FAIL timeout_latency got %0d want 19", seen_at);
    else passes++;
    checks++;
    if (exp_q.size() == 0) $display("[TB] FAIL timeout_rec got record want none queued");
    else begin
      want = exp_q.pop_front();
      if (rec_valid !== 1'b1 || head() !== want)
        $display("[TB] FAIL timeout_rec got v=%b %p want %p", rec_valid, head(), want);
      else passes++;
    end
    tick();
  endtask

  task automatic test_timeout_tie();
    event_valid = 1'b1;
    event_addr = 32'h500;
    event_cycles_back = 8'd2;
    exp_q.push_back(mk_rec(32'h500, 33, 44, 1'b1));
    tick();
    event_valid = 1'b0;
    repeat (16) tick();
    trk_data_valid = 1'b1;
    trk_time_start = 33;
    trk_time_end = 44;
    tick();
    trk_data_valid = 1'b0;
    checks++;
    if (rec_valid !== 1'b0) $display("[TB] FAIL tie_early got valid=%b want 0", rec_valid);
    else passes++;
    tick();
    checks++;
    if (exp_q.size() == 0) $display("[TB] FAIL tie_rec got record want none queued");
    else begin
      want = exp_q.pop_front();
      if (rec_valid !== 1'b1 || head() !== want)
        $display("[TB] FAIL tie_rec got v=%b %p want %p", rec_valid, head(), want);
      else passes++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int popped = 0;
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < 10 && event_ready !== 1'b1; w++) tick();
      event_valid = 1'b1;
      event_addr = 32'h600 + DW'(i);
      event_cycles_back = 8'd0;
      exp_q.push_back(mk_rec(32'h600 + DW'(i), NT, NT, 1'b0));
      tick();
      event_valid = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (event_ready !== 1'b0) $display("[TB] FAIL full_hold_ready got %b want 0", event_ready);
      else passes++;
      tick();
    end
    checks++;
    if (rec_valid !== 1'b1 || rec_addr !== 32'h600)
      $display("[TB] FAIL full_head got v=%b addr=%h want 1 600", rec_valid, rec_addr);
    else passes++;
    rec_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (rec_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL order_rec got %p want none queued", head());
        else begin
          want = exp_q.pop_front();
          if (head() !== want) $display("[TB] FAIL order_rec got %p want %p", head(), want);
          else passes++;
        end
        popped++;
      end
      tick();
      if (k == 0) begin
        rec_ready = 1'b0;
        checks++;
        if (event_ready !== 1'b1) $display("[TB] FAIL push_on_pop_ready got %b want 1", event_ready);
        else passes++;
        rec_ready = 1'b1;
      end
    end
    checks++;
    if (popped != 5 || exp_q.size() != 0)
      $display("[TB] FAIL order_count got %0d left=%0d want 5 0", popped, exp_q.size());
    else passes++;
  endtask

  task automatic test_reset_midquery();
    rec_ready = 1'b0;
    event_valid = 1'b1;
    event_addr = 32'h700;
    event_cycles_back = 8'd0;
    tick();
    event_valid = 1'b0;
    tick();
    checks++;
    if (rec_valid !== 1'b1) $display("[TB] FAIL pre_reset_fill got %b want 1", rec_valid);
    else passes++;
    event_valid = 1'b1;
    event_addr = 32'h710;
    event_cycles_back = 8'd4;
    tick();
    event_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (recalculate_time !== 1'b0 || rec_valid !== 1'b0 || counter !== '0)
      $display("[TB] FAIL async_reset got recalc=%b valid=%b counter=%0d want 0 0 0",
               recalculate_time, rec_valid, counter);
    else passes++;
    tick();
    rst_n = 1'b1;
    rec_ready = 1'b1;
    exp_q.delete();
    tick();
    checks++;
    if (rec_valid !== 1'b0) $display("[TB] FAIL fifo_discarded got %b want 0", rec_valid);
    else passes++;
    event_valid = 1'b1;
    event_addr = 32'h720;
    event_cycles_back = 8'd3;
    trk_data_valid = 1'b1;
    trk_time_start = 77;
    trk_time_end = 78;
    exp_q.push_back(mk_rec(32'h720, 5, 6, 1'b1));
    tick();
    event_valid = 1'b0;
    tick();
    trk_time_start = 5;
    trk_time_end = 6;
    tick();
    trk_data_valid = 1'b0;
    checks++;
    if (rec_valid !== 1'b0) $display("[TB] FAIL stale_arm got valid=%b want 0", rec_valid);
    else passes++;
    tick();
    checks++;
    if (exp_q.size() == 0) $display("[TB] FAIL post_reset_rec got record want none queued");
    else begin
      want = exp_q.pop_front();
      if (rec_valid !== 1'b1 || head() !== want)
        $display("[TB] FAIL post_reset_rec got v=%b %p want %p", rec_valid, head(), want);
      else passes++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_timeout();
    test_timeout_tie();
    test_back_to_back();
    test_reset_midquery();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got no finish want finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/trace_timing_resolver.md
TRACE_TIMING_RESOLVER -- requirements
Module: trace_timing_resolver

Interface
REQ-001 Parameter BUFFER_WIDTH, default 8, SHALL be the depth of the downstream signal_tracker history; a power of 2.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the width of the event address, the counter and the time values.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL be the number of output record slots; a power of 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, SHALL be the maximum wait for a tracker answer.
REQ-005 Port list, clock and reset first:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- event_valid  in  1  a timing query is offered.
- event_ready  out  1  a query is accepted this cycle.
- event_addr  in  DATA_WIDTH  tag carried into the record.
- event_cycles_back  in  8  size of the look-back window in cycles.
- counter  out  DATA_WIDTH  free-running cycle count fed to the tracker.
- recalculate_time  out  1  request to the tracker.
- value_in  out  8  window given to the tracker.
- trk_data_valid  in  1  tracker data_valid.
- trk_time_start  in  DATA_WIDTH signed  tracker time_out[0].
- trk_time_end  in  DATA_WIDTH signed  tracker time_out[1].
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  consumer pops the head.
- rec_addr  out  DATA_WIDTH  head tag.
- rec_start  out  DATA_WIDTH signed  head start time.
- rec_end  out  DATA_WIDTH signed  head end time.
- rec_found  out  1  head holds a tracker answer (0 means timeout or empty window).

Function
REQ-006 counter SHALL increment by 1 every cycle and wrap at 2^DATA_WIDTH.
REQ-007 The FSM SHALL have the states IDLE, ARM, WAIT and PUSH.
REQ-008 event_ready SHALL be 1 only in IDLE; a query is accepted when event_valid and event_ready are both 1.
REQ-009 On acceptance, the block SHALL latch event_addr and set value_in = min(event_cycles_back, BUFFER_WIDTH).
REQ-010 Acceptance with event_cycles_back == 0 SHALL go directly to PUSH with found=0 and start=end=-1.
REQ-011 Acceptance with event_cycles_back > 0 SHALL go to ARM.
REQ-012 recalculate_time SHALL be 1 in ARM and WAIT, and 0 in every other state.
REQ-013 ARM SHALL last exactly 1 cycle, SHALL ignore trk_data_valid (the stale flag is being cleared), and SHALL then go to WAIT.
REQ-014 In WAIT, trk_data_valid == 1 SHALL capture trk_time_start and trk_time_end with found=1, and the FSM SHALL go to PUSH.
REQ-015 A WAIT timer SHALL count from 0; when it reaches TIMEOUT_CYCLES-1 without trk_data_valid, the block SHALL go to PUSH with found=0 and start=end=-1.
REQ-016 trk_data_valid and timeout in the same cycle SHALL resolve as data (found=1).
REQ-017 PUSH SHALL write {addr, start, end, found} into the FIFO when the FIFO is not full, or is full with a pop in the same cycle, and SHALL then go to IDLE.
REQ-018 Otherwise PUSH SHALL hold, with no record lost.
REQ-019 The FIFO SHALL be first-in first-out; rec_* SHALL show the head; a pop SHALL occur on rec_valid && rec_ready.
REQ-020 A simultaneous push and pop SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 Latency, no backpressure, data arriving N cycles after entering WAIT: the record SHALL be visible N+3 cycles after acceptance.
REQ-022 Latency for a zero-window query SHALL be 2 cycles.

Reset
REQ-023 While rst_n == 0, the block SHALL be held as follows:
- state IDLE; counter 0; recalculate_time 0; value_in 0; WAIT timer 0.
- FIFO empty, rec_valid 0; latched record fields 0.
REQ-024 Reset asserted mid-query SHALL abandon the query with no record emitted; FIFO contents SHALL be discarded.
REQ-025 The first acceptance after reset SHALL be possible in the first cycle after rst_n rises.

Structure
REQ-026 Package gouram_timing_pkg SHALL hold the FSM state enum, a record struct typedef {addr, start, end, found}, and the constant NO_TIME = -1.
REQ-027 The FIFO SHALL be a sub-module trace_record_fifo (parameters DEPTH and record type; ports full, empty, push, pop).
REQ-028 The tracker connection SHALL use signal_tracker_if with its TimeTest-consumer view.

Verification
REQ-029 Accept addr=0x100, cycles_back=3; tracker model answers 2 cycles into WAIT with start=10, end=12 -> value_in=3; record {0x100,10,12,1} visible 5 cycles after acceptance.
REQ-030 cycles_back=20 with BUFFER_WIDTH=8 -> value_in=8.
REQ-031 cycles_back=0 -> no recalculate_time pulse; record {addr,-1,-1,0} after 2 cycles.
REQ-032 Tracker silent -> recalculate_time high for exactly 1+16 cycles; record found=0, start=end=-1.
REQ-033 rec_ready=0 and 5 queries -> 4 records stored; 5th held in PUSH with event_ready=0; one pop -> 5th pushed in the same cycle; order preserved.
REQ-034 rst_n low during WAIT -> recalculate_time 0, rec_valid 0, counter 0 immediately; stale trk_data_valid=1 during the next ARM not captured.
